// File: rtl/vga_pkg.sv
// Shared timing constants and types for the VGA scan controller.
package vga_pkg;
  localparam int CLK_DIV  = 2;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam bit SYNC_ACTIVE = 1'b0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef logic [9:0] xcoord_t;
  typedef logic [8:0] ycoord_t;
endpackage

// File: rtl/vga_scan_controller_if.sv
// Pixel-memory address/data port plus VGA connector pins.
interface vga_scan_controller_if;
  import vga_pkg::*;
  xcoord_t    pixel_x;
  ycoord_t    pixel_y;
  logic       pixel;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       vga_de;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       frame_start;

  modport master (
    output pixel_x, pixel_y, vga_hsync, vga_vsync, vga_de,
           vga_r, vga_g, vga_b, frame_start,
    input  pixel
  );
  modport slave (
    input  pixel_x, pixel_y, vga_hsync, vga_vsync, vga_de,
           vga_r, vga_g, vga_b, frame_start,
    output pixel
  );
endinterface

// File: rtl/vga_raster_counter.sv
// Pixel-tick divider and horizontal/vertical raster position counters.
module vga_raster_counter #(
  parameter int CLK_DIV = 2,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int HW      = $clog2(H_TOTAL),
  parameter int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic          tick,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DMAX = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HMAX = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] VMAX = VW'(V_TOTAL - 1);

  logic [DW-1:0] div_cnt;

  assign tick = enable && (div_cnt == DMAX);

  // Divider free-runs while enabled; raster position advances once per tick.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      div_cnt <= (div_cnt == DMAX) ? '0 : div_cnt + 1'b1;
      if (tick) begin
        if (h_cnt == HMAX) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == VMAX) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/vga_scan_controller.sv
// VGA scan controller: raster timing, pixel-memory addressing and a
// two-tick output pipeline keeping syncs, data-enable and colour aligned.
module vga_scan_controller
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = vga_pkg::CLK_DIV,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter bit SYNC_ACTIVE = vga_pkg::SYNC_ACTIVE
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        enable,
  input  logic [11:0] fg_colour,
  input  logic [11:0] bg_colour,
  vga_scan_controller_if.master bus
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam logic [HW-1:0] H_ACT_L = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT_L = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic          tick;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_act, v_act;

  // stage 1
  xcoord_t pixel_x_q;
  ycoord_t pixel_y_q;
  logic    hs1, vs1, de1, fs1;
  // stage 2
  logic    hsync_q, vsync_q, de_q, frame_start_q;
  rgb444_t rgb_q;

  vga_raster_counter #(
    .CLK_DIV(CLK_DIV), .H_TOTAL(HT), .V_TOTAL(VT), .HW(HW), .VW(VW)
  ) u_cnt (
    .clk(HCLK), .rst(HRESET), .enable(enable),
    .tick(tick), .h_cnt(h_cnt), .v_cnt(v_cnt)
  );

  assign h_act = h_cnt < H_ACT_L;
  assign v_act = v_cnt < V_ACT_L;

  // Stage 1: memory address and raw timing flags for the current position.
  always_ff @(posedge HCLK) begin
    if (HRESET || !enable) begin
      pixel_x_q <= '0;
      pixel_y_q <= '0;
      hs1       <= 1'b0;
      vs1       <= 1'b0;
      de1       <= 1'b0;
      fs1       <= 1'b0;
    end else if (tick) begin
      pixel_x_q <= h_act ? xcoord_t'(h_cnt) : '0;
      pixel_y_q <= v_act ? ycoord_t'(v_cnt) : '0;
      hs1       <= (h_cnt >= HS_BEG) && (h_cnt < HS_END);
      vs1       <= (v_cnt >= VS_BEG) && (v_cnt < VS_END);
      de1       <= h_act && v_act;
      fs1       <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  // Stage 2: pin outputs; pixel has had a full tick to return from memory.
  always_ff @(posedge HCLK) begin
    if (HRESET || !enable) begin
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      de_q          <= 1'b0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= tick && fs1;
      if (tick) begin
        hsync_q <= hs1 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_q <= vs1 ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        de_q    <= de1;
        rgb_q   <= de1 ? rgb444_t'(bus.pixel ? fg_colour : bg_colour) : '0;
      end
    end
  end

  assign bus.pixel_x     = pixel_x_q;
  assign bus.pixel_y     = pixel_y_q;
  assign bus.vga_hsync   = hsync_q;
  assign bus.vga_vsync   = vsync_q;
  assign bus.vga_de      = de_q;
  assign bus.vga_r       = rgb_q.r;
  assign bus.vga_g       = rgb_q.g;
  assign bus.vga_b       = rgb_q.b;
  assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench: default-timing DUT plus a shrunken-timing DUT (CLK_DIV=3,
// active-high syncs), both compared every cycle to a position-based model.
module tb_vga_scan_controller;
  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        enable;
  logic [11:0] fg_colour, bg_colour;

  vga_scan_controller_if if_full ();
  vga_scan_controller_if if_small ();

  always #5 HCLK = ~HCLK;

  // Pixel memories: one-cycle registered read, checkerboard contents.
  always @(posedge HCLK) if_full.pixel  <= if_full.pixel_x[0]  ^ if_full.pixel_y[0];
  always @(posedge HCLK) if_small.pixel <= if_small.pixel_x[0] ^ if_small.pixel_y[0];

  vga_scan_controller dut_full (
    .HCLK(HCLK), .HRESET(HRESET), .enable(enable),
    .fg_colour(fg_colour), .bg_colour(bg_colour), .bus(if_full)
  );

  vga_scan_controller #(
    .CLK_DIV(3), .H_ACTIVE(20), .H_FP(4), .H_SYNC(5), .H_BP(3),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_ACTIVE(1'b1)
  ) dut_small (
    .HCLK(HCLK), .HRESET(HRESET), .enable(enable),
    .fg_colour(fg_colour), .bg_colour(bg_colour), .bus(if_small)
  );

  typedef struct packed {
    logic [9:0]  px;
    logic [8:0]  py;
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] rgb;
    logic        fs;
  } obs_t;

  int total = 0;
  int bad   = 0;
  int c     = 0;      // HCLK edges since last reset / enable-low edge
  int hs_first = -1;  // c of first full-DUT hsync assertion
  int fs_first = -1;  // c of first small-DUT frame_start
  logic [11:0] fg_f, bg_f, fg_s, bg_s;  // colours as seen at each DUT's last tick

  // Expected outputs after c edges of running: n ticks have happened; stage 1
  // shows raster position n-1, stage 2 shows position n-2.
  function automatic obs_t model(int cyc, int div, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb, bit sa,
                                 logic [11:0] fg, logic [11:0] bg);
    obs_t o;
    int n, p, h, v, ht, vt;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    n  = cyc / div;
    o.px = '0; o.py = '0; o.hs = ~sa; o.vs = ~sa; o.de = 1'b0; o.rgb = '0; o.fs = 1'b0;
    if (n >= 1) begin
      p = n - 1; h = p % ht; v = (p / ht) % vt;
      o.px = (h < ha) ? 10'(h) : '0;
      o.py = (v < va) ? 9'(v) : '0;
    end
    if (n >= 2) begin
      p = n - 2; h = p % ht; v = (p / ht) % vt;
      o.hs  = (h >= ha + hf && h < ha + hf + hsw) ? sa : ~sa;
      o.vs  = (v >= va + vf && v < va + vf + vsw) ? sa : ~sa;
      o.de  = (h < ha) && (v < va);
      o.rgb = o.de ? ((((h % 2) ^ (v % 2)) != 0) ? fg : bg) : 12'h000;
      o.fs  = (cyc % div == 0) && (h == 0) && (v == 0);
    end
    return o;
  endfunction

  function automatic obs_t grab_full();
    return {if_full.pixel_x, if_full.pixel_y, if_full.vga_hsync, if_full.vga_vsync,
            if_full.vga_de, if_full.vga_r, if_full.vga_g, if_full.vga_b, if_full.frame_start};
  endfunction

  function automatic obs_t grab_small();
    return {if_small.pixel_x, if_small.pixel_y, if_small.vga_hsync, if_small.vga_vsync,
            if_small.vga_de, if_small.vga_r, if_small.vga_g, if_small.vga_b, if_small.frame_start};
  endfunction

  task automatic check_obs(string tag, obs_t got, obs_t exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s c=%0d got px=%0d py=%0d hs=%b vs=%b de=%b rgb=%h fs=%b exp px=%0d py=%0d hs=%b vs=%b de=%b rgb=%h fs=%b",
             tag, c, got.px, got.py, got.hs, got.vs, got.de, got.rgb, got.fs,
             exp.px, exp.py, exp.hs, exp.vs, exp.de, exp.rgb, exp.fs);
    end
  endtask

  task automatic check_int(string tag, int got, int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance k cycles, checking both DUTs after every edge; colours wander.
  task automatic step(int k);
    for (int i = 0; i < k; i++) begin
      @(posedge HCLK);
      #1;
      if (HRESET || !enable) c = 0; else c++;
      if (c > 0 && c % 2 == 0) begin fg_f = fg_colour; bg_f = bg_colour; end
      if (c > 0 && c % 3 == 0) begin fg_s = fg_colour; bg_s = bg_colour; end
      if (c > 0 && hs_first < 0 && if_full.vga_hsync == 1'b0) hs_first = c;
      if (c > 0 && fs_first < 0 && if_small.frame_start == 1'b1) fs_first = c;
      check_obs("full",  grab_full(),  model(c, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, fg_f, bg_f));
      check_obs("small", grab_small(), model(c, 3, 20, 4, 5, 3, 10, 2, 2, 3, 1'b1, fg_s, bg_s));
      if ($urandom_range(0, 15) == 0) fg_colour = 12'($urandom);
      if ($urandom_range(0, 15) == 0) bg_colour = 12'($urandom);
    end
  endtask

  initial begin
    HRESET = 1'b1; enable = 1'b1;
    fg_colour = 12'hF00; bg_colour = 12'h00F;
    fg_f = fg_colour; bg_f = bg_colour; fg_s = fg_colour; bg_s = bg_colour;
    step(5);
    HRESET = 1'b0;
    step(1700);
    check_int("first_hsync_full", hs_first, 1316);
    check_int("first_fs_small", fs_first, 6);
    step(3500);
    // mid-line reset
    HRESET = 1'b1; step(2); HRESET = 1'b0;
    step(3000);
    // enable gating mid-line
    enable = 1'b0; step(1000); enable = 1'b1;
    step(3000);
    // random restarts
    for (int r = 0; r < 4; r++) begin
      step($urandom_range(300, 1500));
      if (r[0]) begin HRESET = 1'b1; step($urandom_range(1, 4)); HRESET = 1'b0; end
      else      begin enable = 1'b0; step($urandom_range(1, 50)); enable = 1'b1; end
    end
    step(2000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
